// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame packer.
// FRAME_CHECKSUM_EN selects the 4-byte (checksummed) frame; undefined gives 3 bytes.
package adc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
    localparam int unsigned FRAME_LEN_MAX = 4;
    localparam int unsigned IDX_W         = $clog2(FRAME_LEN_MAX);

    localparam int unsigned SEQ_MSB  = 7;
    localparam int unsigned SEQ_LSB  = 3;
    localparam int unsigned CHAN_MSB = 2;
    localparam int unsigned CHAN_LSB = 0;

`ifdef FRAME_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2);
`endif

    function automatic logic [7:0] make_header(input logic [4:0] seq, input logic [2:0] chan);
        logic [7:0] h;
        h = '0;
        h[SEQ_MSB:SEQ_LSB]   = seq;
        h[CHAN_MSB:CHAN_LSB] = chan;
        return h;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset (flops clear to 0).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/adc_frame_packer.sv
// Packs ADC samples into SYNC/header/data[/checksum] byte frames for a UART transmitter.
// Checksum byte is built only when FRAME_CHECKSUM_EN is defined.
module adc_frame_packer
    import adc_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    input  logic [2:0] sample_chan,
    input  logic       tx_ready,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic [7:0] overrun_count
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [4:0]       seq_q, seq_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       frame_data_q, frame_data_d;
    logic [2:0]       frame_chan_q, frame_chan_d;
    logic             pend_q, pend_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic [2:0]       hold_chan_q, hold_chan_d;
    logic [7:0]       overrun_q, overrun_d;

    logic             tx_ready_s;
    logic             transfer;
    logic [IDX_W-1:0] nxt_idx;
    logic [7:0]       header;
    logic [7:0]       next_byte;

    sync_2ff #(
        .WIDTH (1)
    ) u_ready_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tx_ready),
        .q     (tx_ready_s)
    );

    // Byte that follows the current one; header uses the frame's own seq value.
    always_comb begin
        nxt_idx   = idx_q + IDX_W'(1);
        header    = make_header(seq_q, frame_chan_q);
        next_byte = SYNC_BYTE;
        case (nxt_idx)
            IDX_W'(1): next_byte = header;
            IDX_W'(2): next_byte = frame_data_q;
`ifdef FRAME_CHECKSUM_EN
            IDX_W'(3): next_byte = 8'd0 - (header + frame_data_q);
`endif
            default:   next_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        seq_d        = seq_q;
        tx_data_d    = tx_data_q;
        frame_data_d = frame_data_q;
        frame_chan_d = frame_chan_q;
        pend_d       = pend_q;
        hold_data_d  = hold_data_q;
        hold_chan_d  = hold_chan_q;
        overrun_d    = overrun_q;
        transfer     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    transfer     = 1'b1;
                    frame_data_d = hold_data_q;
                    frame_chan_d = hold_chan_q;
                    idx_d        = '0;
                    tx_data_d    = SYNC_BYTE;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (!tx_ready_s) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (tx_ready_s) begin
                    if (idx_q == LAST_IDX) begin
                        seq_d   = seq_q + 5'd1;
                        state_d = IDLE;
                    end else begin
                        idx_d     = nxt_idx;
                        tx_data_d = next_byte;
                        state_d   = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer frees the holding register in the same cycle a new sample may land in it.
        if (transfer) begin
            pend_d = 1'b0;
        end
        if (sample_valid) begin
            if (pend_q && !transfer) begin
                if (overrun_q != '1) begin
                    overrun_d = overrun_q + 8'd1;
                end
            end else begin
                pend_d      = 1'b1;
                hold_data_d = sample_data;
                hold_chan_d = sample_chan;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            seq_q        <= '0;
            tx_data_q    <= '0;
            frame_data_q <= '0;
            frame_chan_q <= '0;
            pend_q       <= 1'b0;
            hold_data_q  <= '0;
            hold_chan_q  <= '0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            seq_q        <= seq_d;
            tx_data_q    <= tx_data_d;
            frame_data_q <= frame_data_d;
            frame_chan_q <= frame_chan_d;
            pend_q       <= pend_d;
            hold_data_q  <= hold_data_d;
            hold_chan_q  <= hold_chan_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx_send       = (state_q == SEND);
    assign tx_data       = tx_data_q;
    assign busy          = (state_q != IDLE) | pend_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed self-checking bench for adc_frame_packer with a simple UART ready model.
// Build with or without FRAME_CHECKSUM_EN; expected frames follow the same macro.
module tb_adc_frame_packer;

`ifdef FRAME_CHECKSUM_EN
    localparam int FL = 4;
`else
    localparam int FL = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic [2:0] sample_chan;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       busy;
    logic [7:0] overrun_count;

    int         errors = 0;
    int         checks = 0;
    logic       stall  = 1'b0;
    logic [7:0] got_q[$];

    adc_frame_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .sample_chan   (sample_chan),
        .tx_ready      (tx_ready),
        .tx_send       (tx_send),
        .tx_data       (tx_data),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: takes the byte, drops ready one cycle later, raises it 20 cycles after that.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst_n && !stall && tx_send && tx_ready) begin
                got_q.push_back(tx_data);
                @(posedge clk); #1;
                if (rst_n) begin
                    tx_ready = 1'b0;
                    for (int k = 0; k < 20; k++) begin
                        @(posedge clk); #1;
                        if (!rst_n) break;
                    end
                end
                tx_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_sample(input logic [7:0] d, input logic [2:0] c);
        sample_data  = d;
        sample_chan  = c;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        for (int k = 0; k < 400 * n; k++) begin
            if (got_q.size() >= n) break;
            @(posedge clk); #2;
        end
        chk("byte_count", got_q.size(), n);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400; k++) begin
            if (!busy && tx_ready) break;
            @(posedge clk); #1;
        end
        chk("idle_busy", busy, 0);
    endtask

    task automatic check_frame(input int base, input logic [7:0] hdr, input logic [7:0] dat,
                               input logic [7:0] cs);
        logic [7:0] b;
        b = (got_q.size() > base)     ? got_q[base]     : 8'hxx;
        chk("frame_sync", b, 8'hA5);
        b = (got_q.size() > base + 1) ? got_q[base + 1] : 8'hxx;
        chk("frame_header", b, hdr);
        b = (got_q.size() > base + 2) ? got_q[base + 2] : 8'hxx;
        chk("frame_data", b, dat);
`ifdef FRAME_CHECKSUM_EN
        b = (got_q.size() > base + 3) ? got_q[base + 3] : 8'hxx;
        chk("frame_checksum", b, cs);
`else
        if (cs == 8'h00) chk("frame_len", got_q.size(), base + FL);
`endif
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        sample_chan  = '0;
        repeat (3) @(posedge clk); #1;

        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun_count, 0);

        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // First frame, with latency checks: data 3C on channel 5, seq 0
        sample_data  = 8'h3C;
        sample_chan  = 3'd5;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("lat_busy_pending", busy, 1);
        chk("lat_no_send_yet", tx_send, 0);
        @(posedge clk); #1;
        chk("lat_send", tx_send, 1);
        chk("lat_sync_byte", tx_data, 8'hA5);
        wait_bytes(FL);
        wait_idle();
        check_frame(0, 8'h05, 8'h3C, 8'hBF);
`ifdef FRAME_CHECKSUM_EN
        chk("tx_data_held", tx_data, 8'hBF);
`else
        chk("tx_data_held", tx_data, 8'h3C);
`endif
        got_q.delete();

        // Zero sample is still sent: seq 1, chan 2 -> header 0A
        send_sample(8'h00, 3'd2);
        wait_bytes(FL);
        wait_idle();
        check_frame(0, 8'h0A, 8'h00, 8'hF6);
        got_q.delete();

        // Restart seq from 0 and run 33 frames on chan 0 to see the wrap
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 33; i++) begin
            logic [7:0] exp_hdr;
            exp_hdr = 8'((i % 32) * 8);
            send_sample(8'(i), 3'd0);
            wait_bytes(FL);
            wait_idle();
            chk("seq_header", (got_q.size() > 1) ? got_q[1] : 8'hxx, exp_hdr);
            chk("seq_data", (got_q.size() > 2) ? got_q[2] : 8'hxx, 8'(i));
            got_q.delete();
        end

        // Back-to-back samples (second lands on the transfer cycle), then two drops
        send_sample(8'h11, 3'd1);
        send_sample(8'h22, 3'd3);
        chk("sim_no_overrun", overrun_count, 0);
        repeat (3) @(posedge clk); #1;
        send_sample(8'h33, 3'd4);
        @(posedge clk); #1;
        send_sample(8'h44, 3'd5);
        chk("overrun_two", overrun_count, 2);
        wait_bytes(2 * FL);
        wait_idle();
        check_frame(0, 8'h09, 8'h11, 8'hE6);
        check_frame(FL, 8'h13, 8'h22, 8'hCB);
        got_q.delete();

        // Reset while the data byte is in SEND (seq 3, chan 7)
        send_sample(8'h55, 3'd7);
        wait_bytes(3);
        chk("pre_reset_send", tx_send, 1);
        chk("pre_reset_data", tx_data, 8'h55);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_send", tx_send, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun_count, 0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        got_q.delete();
        send_sample(8'h44, 3'd6);
        wait_bytes(FL);
        wait_idle();
        check_frame(0, 8'h06, 8'h44, 8'hB6);
        got_q.delete();

        // Saturation: UART stalled, holding register full, then 300 drops
        stall = 1'b1;
        send_sample(8'h01, 3'd0);
        send_sample(8'h02, 3'd0);
        chk("sat_start", overrun_count, 0);
        for (int i = 0; i < 254; i++) send_sample(8'h03, 3'd0);
        chk("sat_254", overrun_count, 254);
        send_sample(8'h03, 3'd0);
        chk("sat_255", overrun_count, 255);
        for (int i = 0; i < 45; i++) send_sample(8'h03, 3'd0);
        chk("sat_hold", overrun_count, 255);
        chk("sat_stuck_send", tx_send, 1);
        chk("sat_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Packs 8-bit ADC samples into fixed serial frames for the UART transmitter. Sits between the ADC controller (sample source) and the UART transmitter (byte sink): it takes each converted sample plus its channel number and emits a sync byte, a header, the data byte and, optionally, a checksum byte. Bytes are handed over one at a time through a send/ready handshake. The packer replaces the "send whenever data is non-zero" rule: zero-valued samples are transmitted like any other value.

## Interface
- SYNC_BYTE, 8'hA5, first byte of every frame
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- sample_valid  in  1  one-cycle pulse: sample_data/sample_chan are valid this cycle
- sample_data  in  8  converted ADC value
- sample_chan  in  3  ADC input channel of the sample
- tx_ready  in  1  UART transmitter idle/accepting; comes from the slower baud-tick domain and is synchronized internally
- tx_send  out  1  request to the UART to transmit tx_data
- tx_data  out  8  byte to transmit; stable while tx_send is high
- busy  out  1  high while a frame is in progress or a sample is pending
- overrun_count  out  8  saturating count of dropped samples

## Operation
- One-deep holding register (pending flag, data, chan).
  - A sample_valid pulse with the holding register empty captures the sample.
  - A sample_valid pulse with the holding register full drops the new sample, keeps the old one, and increments overrun_count (saturates at 255).
- Frame bytes, in order:
  - SYNC_BYTE
  - header = {seq[4:0], chan[2:0]}
  - data
  - checksum = (-(header + data)) mod 256, so header+data+checksum ≡ 0 mod 256
- seq is a 5-bit frame counter. It increments after the last byte of each frame and wraps from 31 to 0.
- FSM states:
  - IDLE: holding register pending -> move it into the frame register, clear pending, byte index = 0, go to SEND.
  - SEND: tx_send=1, tx_data=frame byte[index]. When synchronized tx_ready_s==0 (UART accepted), go to DONE.
  - DONE: tx_send=0. When tx_ready_s==1: if index is the last byte, increment seq and go to IDLE; otherwise increment index and go to SEND.
- The holding register is free again as soon as its contents move to the frame register. A new sample can be captured during transmission.
- Simultaneous sample_valid and IDLE->SEND transfer in the same cycle: the transfer clears pending and the new sample is captured. No drop, no overrun.
- busy = (state != IDLE) | pending.

## Timing
- tx_ready passes through a 2-flop synchronizer. Every handshake decision uses tx_ready_s, which is 2 cycles late.
- Latency: sample_valid high in cycle N -> pending set at edge N+1 -> state SEND and tx_send high from edge N+2 (packer idle beforehand).
- tx_data changes only on entry to SEND. tx_data is held for the whole SEND period and does not change in DONE.
- Minimum per byte: 1 cycle SEND plus the synchronizer delay for each tx_ready edge. There is no timeout; the packer waits on tx_ready indefinitely.
- Reset values: tx_send=0, tx_data=8'h00, busy=0, overrun_count=0, seq=0, pending=0, state=IDLE, synchronizer flops=0.
- Reset asserted mid-frame: the frame is aborted and tx_send falls asynchronously. After reset release, the next frame starts with SYNC_BYTE and seq=0.

## Configuration
- FRAME_CHECKSUM_EN defined: 4-byte frame (SYNC, header, data, checksum); last index = 3.
- FRAME_CHECKSUM_EN undefined: 3-byte frame (SYNC, header, data); last index = 2; no checksum logic is built.

## Structure
- Package adc_frame_pkg holds:
  - FSM state enum (IDLE, SEND, DONE)
  - default SYNC_BYTE
  - FRAME_LEN_MAX = 4
  - header field positions (SEQ_MSB=7, SEQ_LSB=3, CHAN_MSB=2, CHAN_LSB=0)
- Sub-module sync_2ff: generic 2-flop synchronizer with async active-low reset, used for tx_ready.

## Test plan
- One sample, data 8'h3C, chan 5, tx_ready modeled as a UART (drops 1 cycle after send, rises 20 cycles later) -> bytes A5, 05, 3C, BF with checksum; A5, 05, 3C without.
- Sample with data 8'h00 -> full frame is sent (no zero suppression), data byte 00.
- 33 consecutive frames on chan 0 -> header seq field runs 0..31 then wraps to 0 (33rd header = 8'h00).
- Three sample_valid pulses during one frame -> first is captured, next two are dropped, overrun_count=2; the second frame carries the first-captured sample.
- Reset pulled low while in SEND of the data byte -> tx_send=0 immediately, busy=0. The next sample produces A5 with header seq=0.
- 300 dropped samples -> overrun_count saturates at 255.
